// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM state encoding and register-index constants.
package pipeline_hazard_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_X0 = '0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction reading the register an EX-stage load writes.
module load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic [REG_W-1:0] rd,
   input  logic             is_load,
   input  logic             we_reg,
   output logic             hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = use_rs1 && (rs1 == rd);
   assign rs2_hit = use_rs2 && (rs2 == rd);
   // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
   assign hazard  = is_load && we_reg && (rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes, data-memory wait holds and timeout fault.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_we_reg,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_nop,
   output logic             exmem_hold,
   output logic [1:0]       state_o,
   output logic             timeout_err,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LIMIT   = WW'(MEM_TIMEOUT);

   state_e        state, state_next;
   logic [FW-1:0] flush_cnt, flush_next;
   logic [WW-1:0] wait_cnt, wait_next;
   logic          luh;
   logic          mstall;
   logic          any_bubble;

   load_use_detect u_luh (
      .rs1     (id_rs1),
      .rs2     (id_rs2),
      .use_rs1 (id_use_rs1),
      .use_rs2 (id_use_rs2),
      .rd      (ex_rd),
      .is_load (ex_is_load),
      .we_reg  (ex_we_reg),
      .hazard  (luh)
   );

   assign mstall     = mem_req && !mem_ready;
   assign any_bubble = pc_stall || ifid_flush || idex_nop || exmem_hold;
   assign state_o    = state;

   always_comb begin
      state_next = state;
      flush_next = flush_cnt;
      wait_next  = wait_cnt;
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_nop   = 1'b0;
      exmem_hold = 1'b0;
      if (!rst) begin
         idex_nop = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (mstall) begin
                  // EX is frozen, so a coincident redirect is re-presented after the wait.
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  exmem_hold = 1'b1;
                  state_next = MEM_WAIT;
                  wait_next  = WW'(1);
               end else if (ex_redirect) begin
                  ifid_flush = 1'b1;
                  idex_nop   = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_next = FLUSH;
                     flush_next = FLUSH_RELOAD;
                  end
               end else if (luh) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_nop   = 1'b1;
               end
            end
            FLUSH: begin
               if (mstall) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  exmem_hold = 1'b1;
                  state_next = MEM_WAIT;
                  wait_next  = WW'(1);
               end else begin
                  ifid_flush = 1'b1;
                  idex_nop   = 1'b1;
                  if (ex_redirect && (FLUSH_CYCLES > 1)) begin
                     flush_next = FLUSH_RELOAD;
                  end else if (flush_cnt <= FW'(1)) begin
                     flush_next = '0;
                     state_next = RUN;
                  end else begin
                     flush_next = flush_cnt - FW'(1);
                  end
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  wait_next  = '0;
                  state_next = (flush_cnt != '0) ? FLUSH : RUN;
               end else begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  exmem_hold = 1'b1;
                  if (wait_cnt == WAIT_LIMIT) begin
                     state_next = ERROR;
                  end else begin
                     wait_next = wait_cnt + WW'(1);
                  end
               end
            end
            ERROR: begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               exmem_hold = 1'b1;
               idex_nop   = 1'b1;
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         flush_cnt   <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
         bubble_cnt  <= '0;
      end else begin
         state       <= state_next;
         flush_cnt   <= flush_next;
         wait_cnt    <= wait_next;
         timeout_err <= timeout_err || (state_next == ERROR);
         if (any_bubble && !(&bubble_cnt)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

endmodule
